// File: rtl/vec_pkg.sv
// Shared constants, types and helpers for the vector issue path.
package vec_pkg;

    localparam int NUM_LANES = 4;
    localparam int MAX_VL    = 64;
    localparam int VL_W      = $clog2(MAX_VL + 1);
    localparam int OP_W      = 6;
    localparam int TAG_W     = 4;

    typedef logic [OP_W-1:0]  vop_t;
    typedef logic [TAG_W-1:0] vtag_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        ZERO  = 2'd2
    } seq_state_e;

    // Saturate a requested vector length to the architectural maximum.
    function automatic logic [VL_W-1:0] clamp_vl(input logic [VL_W-1:0] vl);
        logic [VL_W-1:0] lim;
        lim = VL_W'(MAX_VL);
        if (vl > lim) begin
            clamp_vl = lim;
        end else begin
            clamp_vl = vl;
        end
    endfunction

endpackage

// File: rtl/lane_sequencer_mask_gen.sv
// Per-lane active mask and last-beat flag for one element group.
// Shared with the lane writeback path, so it stays purely combinational.
module lane_mask_gen #(
    parameter int NUM_LANES = 4,
    parameter int VL_W      = 7
) (
    input  logic [VL_W:0]        i_base,
    input  logic [VL_W-1:0]      i_vl_eff,
    output logic [NUM_LANES-1:0] o_lane_mask,
    output logic                 o_lane_last
);

    logic [VL_W:0] w_vl_ext;

    assign w_vl_ext = {1'b0, i_vl_eff};

    // One extra index bit keeps base+lane from wrapping near MAX_VL.
    always_comb begin
        o_lane_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            o_lane_mask[i] = ((i_base + (VL_W + 1)'(i)) < w_vl_ext);
        end
        o_lane_last = ((i_base + (VL_W + 1)'(NUM_LANES)) >= w_vl_ext);
    end

endmodule

// File: rtl/lane_sequencer.sv
// Breaks one vector instruction at a time into NUM_LANES-wide beats with
// lane backpressure, flush and per-tag completion reporting.
module lane_sequencer
    import vec_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [OP_W-1:0]      instr_op,
    input  logic [VL_W-1:0]      instr_vl,
    input  logic [TAG_W-1:0]     instr_tag,
    output logic                 lane_valid,
    input  logic                 lane_ready,
    output logic [OP_W-1:0]      lane_op,
    output logic [VL_W-1:0]      lane_elem_base,
    output logic [NUM_LANES-1:0] lane_mask,
    output logic                 lane_last,
    output logic [TAG_W-1:0]     lane_tag,
    input  logic                 flush,
    output logic                 done_valid,
    output logic [TAG_W-1:0]     done_tag,
    output logic                 busy
);

    seq_state_e            r_state;
    seq_state_e            w_state_nxt;
    vop_t                  r_op;
    vop_t                  w_op_nxt;
    vtag_t                 r_tag;
    vtag_t                 w_tag_nxt;
    logic [VL_W-1:0]       r_vl;
    logic [VL_W-1:0]       w_vl_nxt;
    logic [VL_W:0]         r_base;
    logic [VL_W:0]         w_base_nxt;

    logic                  r_lane_valid;
    logic                  w_lane_valid_nxt;
    vop_t                  r_lane_op;
    logic [VL_W-1:0]       r_lane_elem_base;
    logic [NUM_LANES-1:0]  r_lane_mask;
    logic                  r_lane_last;
    vtag_t                 r_lane_tag;
    logic                  r_done_valid;
    logic                  w_done_valid_nxt;
    vtag_t                 r_done_tag;
    vtag_t                 w_done_tag_nxt;
    logic                  r_busy;

    logic [NUM_LANES-1:0]  w_mask_nxt;
    logic                  w_last_nxt;
    logic                  w_hs;

    // Mask for the beat that will be presented next cycle.
    lane_mask_gen #(
        .NUM_LANES (NUM_LANES),
        .VL_W      (VL_W)
    ) u_mask_gen (
        .i_base      (w_base_nxt),
        .i_vl_eff    (w_vl_nxt),
        .o_lane_mask (w_mask_nxt),
        .o_lane_last (w_last_nxt)
    );

    assign w_hs        = r_lane_valid && lane_ready;
    assign instr_ready = (r_state == IDLE);

    // Next-state and next-beat selection.
    always_comb begin
        w_state_nxt      = r_state;
        w_op_nxt         = r_op;
        w_tag_nxt        = r_tag;
        w_vl_nxt         = r_vl;
        w_base_nxt       = r_base;
        w_lane_valid_nxt = 1'b0;
        w_done_valid_nxt = 1'b0;
        w_done_tag_nxt   = r_done_tag;
        case (r_state)
            IDLE: begin
                if (instr_valid && instr_ready) begin
                    w_op_nxt   = instr_op;
                    w_tag_nxt  = instr_tag;
                    w_vl_nxt   = clamp_vl(instr_vl);
                    w_base_nxt = '0;
                    if (clamp_vl(instr_vl) == '0) begin
                        w_state_nxt      = ZERO;
                        w_done_valid_nxt = 1'b1;
                        w_done_tag_nxt   = instr_tag;
                    end else begin
                        w_state_nxt      = ISSUE;
                        w_lane_valid_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ZERO: begin
                w_state_nxt = IDLE;
            end
            ISSUE: begin
                // A last-beat handshake takes priority over a same-cycle flush.
                if (w_hs && r_lane_last) begin
                    w_state_nxt      = IDLE;
                    w_done_valid_nxt = 1'b1;
                    w_done_tag_nxt   = r_tag;
                end else if (flush) begin
                    w_state_nxt = IDLE;
                end else if (w_hs) begin
                    w_base_nxt       = r_base + (VL_W + 1)'(NUM_LANES);
                    w_lane_valid_nxt = 1'b1;
                end else begin
                    w_lane_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, instruction context and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state          <= IDLE;
            r_op             <= '0;
            r_tag            <= '0;
            r_vl             <= '0;
            r_base           <= '0;
            r_lane_valid     <= 1'b0;
            r_lane_op        <= '0;
            r_lane_elem_base <= '0;
            r_lane_mask      <= '0;
            r_lane_last      <= 1'b0;
            r_lane_tag       <= '0;
            r_done_valid     <= 1'b0;
            r_done_tag       <= '0;
            r_busy           <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_op         <= w_op_nxt;
            r_tag        <= w_tag_nxt;
            r_vl         <= w_vl_nxt;
            r_base       <= w_base_nxt;
            r_lane_valid <= w_lane_valid_nxt;
            r_done_valid <= w_done_valid_nxt;
            r_done_tag   <= w_done_tag_nxt;
            r_busy       <= (w_state_nxt != IDLE);
            if (w_lane_valid_nxt) begin
                r_lane_op        <= w_op_nxt;
                r_lane_elem_base <= w_base_nxt[VL_W-1:0];
                r_lane_mask      <= w_mask_nxt;
                r_lane_last      <= w_last_nxt;
                r_lane_tag       <= w_tag_nxt;
            end else begin
                r_lane_op        <= '0;
                r_lane_elem_base <= '0;
                r_lane_mask      <= '0;
                r_lane_last      <= 1'b0;
                r_lane_tag       <= '0;
            end
        end
    end

    assign lane_valid     = r_lane_valid;
    assign lane_op        = r_lane_op;
    assign lane_elem_base = r_lane_elem_base;
    assign lane_mask      = r_lane_mask;
    assign lane_last      = r_lane_last;
    assign lane_tag       = r_lane_tag;
    assign done_valid     = r_done_valid;
    assign done_tag       = r_done_tag;
    assign busy           = r_busy;

endmodule
